// File: rtl/button_hold_fsm_pkg.sv
// Shared types and defaults for the button-hold safety path.
package safety_pkg;

    typedef enum logic [1:0] {
        BTN_IDLE    = 2'd0,
        BTN_PRESSED = 2'd1,
        BTN_HELD    = 2'd2
    } btn_state_t;

    // 1 s at 50 MHz
    localparam int LONG_PRESS_CYCLES = 50_000_000;
    localparam int HOLD_CNT_W        = 26;

endpackage

// File: rtl/button_hold_fsm_if.sv
// Button level / clear in, event pulses and e-stop latch out.
interface button_hold_fsm_if;
    logic       ButtonIn;
    logic       clear;
    logic       press_pulse;
    logic       release_pulse;
    logic       long_pulse;
    logic       estop;
    logic [1:0] state;

    modport master (
        output ButtonIn, clear,
        input  press_pulse, release_pulse, long_pulse, estop, state
    );

    modport slave (
        input  ButtonIn, clear,
        output press_pulse, release_pulse, long_pulse, estop, state
    );
endinterface

// File: rtl/button_hold_fsm_hold_timer.sv
// Saturating hold counter; tc flags that the hold has reached LONG_CYCLES.
module hold_timer #(
    parameter int LONG_CYCLES = 8,
    parameter int CNT_W       = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic en,
    input  logic clr,
    output logic tc
);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(LONG_CYCLES);

    logic [CNT_W-1:0] r_count;

    // clr has priority; the count freezes at LIMIT so it can never wrap
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            r_count <= '0;
        else if (clr)
            r_count <= '0;
        else if (en && (r_count != LIMIT))
            r_count <= r_count + CNT_W'(1);
    end

    assign tc = (r_count == LIMIT);
endmodule

// File: rtl/button_hold_fsm.sv
// Turns the debounced button level into press/release/long events and an e-stop latch.
module button_hold_fsm
    import safety_pkg::*;
#(
    parameter int LONG_CYCLES = LONG_PRESS_CYCLES,
    parameter int CNT_W       = HOLD_CNT_W
) (
    input  logic              clock,
    input  logic              reset_n,
    button_hold_fsm_if.slave  bus
);
    if (CNT_W < $clog2(LONG_CYCLES + 1)) begin : g_bad_cnt_w
        $error("button_hold_fsm: CNT_W too narrow for LONG_CYCLES");
    end

    btn_state_t r_state;
    logic       r_press;
    logic       r_release;
    logic       r_long;
    logic       r_estop;
    logic       w_en;
    logic       w_clr;
    logic       w_tc;

    // Count only while the hold is still timing; illegal states also wipe the count
    assign w_en  = bus.ButtonIn && ((r_state == BTN_IDLE) || (r_state == BTN_PRESSED));
    assign w_clr = !bus.ButtonIn || !((r_state == BTN_IDLE) || (r_state == BTN_PRESSED) ||
                                      (r_state == BTN_HELD));

    hold_timer #(
        .LONG_CYCLES (LONG_CYCLES),
        .CNT_W       (CNT_W)
    ) u_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .en      (w_en),
        .clr     (w_clr),
        .tc      (w_tc)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= BTN_IDLE;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_long    <= 1'b0;
            r_estop   <= 1'b0;
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_long    <= 1'b0;
            case (r_state)
                BTN_IDLE: begin
                    // A press in the same cycle as clear wins and leaves estop alone
                    if (bus.ButtonIn) begin
                        r_state <= BTN_PRESSED;
                        r_press <= 1'b1;
                    end else if (bus.clear) begin
                        r_estop <= 1'b0;
                    end
                end
                BTN_PRESSED: begin
                    if (!bus.ButtonIn) begin
                        r_state   <= BTN_IDLE;
                        r_release <= 1'b1;
                    end else if (w_tc) begin
                        r_state <= BTN_HELD;
                        r_long  <= 1'b1;
                        r_estop <= 1'b1;
                    end
                end
                BTN_HELD: begin
                    if (!bus.ButtonIn) begin
                        r_state   <= BTN_IDLE;
                        r_release <= 1'b1;
                    end
                end
                default: r_state <= BTN_IDLE;
            endcase
        end
    end

    assign bus.press_pulse   = r_press;
    assign bus.release_pulse = r_release;
    assign bus.long_pulse    = r_long;
    assign bus.estop         = r_estop;
    assign bus.state         = r_state;
endmodule

// File: tb/tb_button_hold_fsm.sv
// Directed bench for button_hold_fsm with an 8-cycle long-press threshold.
module tb_button_hold_fsm;
    logic clock;
    logic reset_n;
    int   n_checks;
    int   n_fail;

    button_hold_fsm_if bus ();

    button_hold_fsm #(
        .LONG_CYCLES (8),
        .CNT_W       (4)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        logic [5:0] obs;
        reset_n      = 1'b0;
        bus.ButtonIn = 1'b1;
        bus.clear    = 1'b0;
        #2;
        for (int i = 0; i < 3; i++) begin
            tick();
            obs = {bus.press_pulse, bus.release_pulse, bus.long_pulse, bus.estop, bus.state};
            n_checks++;
            if (obs !== 6'b0) begin
                n_fail++;
                $display("FAIL reset_outputs cycle %0d: got %b want 000000", i, obs);
            end
        end
        #2 reset_n = 1'b1;
        tick();
        n_checks++;
        if (bus.press_pulse !== 1'b1 || bus.state !== 2'd1) begin
            n_fail++;
            $display("FAIL reset_first_press: press=%b state=%0d want press=1 state=1",
                     bus.press_pulse, bus.state);
        end
        tick();
        n_checks++;
        if (bus.press_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_press_width: press=%b want 0", bus.press_pulse);
        end
        bus.ButtonIn = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_short_press();
        int np, nr, nl;
        np = 0; nr = 0; nl = 0;
        bus.ButtonIn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            np += int'(bus.press_pulse);
            nr += int'(bus.release_pulse);
            nl += int'(bus.long_pulse);
        end
        bus.ButtonIn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            np += int'(bus.press_pulse);
            nr += int'(bus.release_pulse);
            nl += int'(bus.long_pulse);
        end
        n_checks++;
        if (np != 1 || nr != 1 || nl != 0) begin
            n_fail++;
            $display("FAIL short_press_pulses: press=%0d release=%0d long=%0d want 1 1 0",
                     np, nr, nl);
        end
        n_checks++;
        if (bus.estop !== 1'b0 || bus.state !== 2'd0) begin
            n_fail++;
            $display("FAIL short_press_end: estop=%b state=%0d want 0 0", bus.estop, bus.state);
        end
    endtask

    task automatic test_long_press();
        int p_at, l_at, nl;
        p_at = -1; l_at = -1; nl = 0;
        bus.ButtonIn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.press_pulse === 1'b1 && p_at < 0) p_at = i;
            if (bus.long_pulse === 1'b1) begin
                nl++;
                if (l_at < 0) l_at = i;
            end
        end
        n_checks++;
        if (p_at != 0 || l_at - p_at != 8 || nl != 1) begin
            n_fail++;
            $display("FAIL long_press_timing: press_at=%0d long_at=%0d count=%0d want 0 8 1",
                     p_at, l_at, nl);
        end
        n_checks++;
        if (bus.estop !== 1'b1 || bus.state !== 2'd2) begin
            n_fail++;
            $display("FAIL long_press_held: estop=%b state=%0d want 1 2", bus.estop, bus.state);
        end
        bus.ButtonIn = 1'b0;
        tick();
        n_checks++;
        if (bus.release_pulse !== 1'b1 || bus.state !== 2'd0 || bus.estop !== 1'b1) begin
            n_fail++;
            $display("FAIL long_release: rel=%b state=%0d estop=%b want 1 0 1",
                     bus.release_pulse, bus.state, bus.estop);
        end
        tick();
        n_checks++;
        if (bus.release_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL long_release_width: rel=%b want 0", bus.release_pulse);
        end
    endtask

    task automatic test_clear_rules();
        // clear while the button is held down
        bus.ButtonIn = 1'b1;
        tick();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        tick();
        n_checks++;
        if (bus.estop !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_while_pressed: estop=%b want 1", bus.estop);
        end
        bus.ButtonIn = 1'b0;
        tick();
        tick();
        n_checks++;
        if (bus.estop !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_not_remembered: estop=%b want 1", bus.estop);
        end
        // clear and a new press together: the press wins
        bus.ButtonIn = 1'b1;
        bus.clear    = 1'b1;
        tick();
        bus.clear = 1'b0;
        n_checks++;
        if (bus.press_pulse !== 1'b1 || bus.estop !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_vs_press: press=%b estop=%b want 1 1", bus.press_pulse, bus.estop);
        end
        bus.ButtonIn = 1'b0;
        tick();
        tick();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        n_checks++;
        if (bus.estop !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_idle: estop=%b want 0", bus.estop);
        end
    endtask

    task automatic test_reset_mid_hold();
        int p_at, l_at, nr, nl;
        logic [5:0] obs;
        nr = 0; nl = 0;
        bus.ButtonIn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            nr += int'(bus.release_pulse);
            nl += int'(bus.long_pulse);
        end
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            obs = {bus.press_pulse, bus.release_pulse, bus.long_pulse, bus.estop, bus.state};
            nr += int'(bus.release_pulse);
            nl += int'(bus.long_pulse);
            n_checks++;
            if (obs !== 6'b0) begin
                n_fail++;
                $display("FAIL midhold_reset_outputs cycle %0d: got %b want 000000", i, obs);
            end
        end
        #2 reset_n = 1'b1;
        p_at = -1; l_at = -1;
        for (int i = 0; i < 12; i++) begin
            tick();
            nr += int'(bus.release_pulse);
            if (bus.press_pulse === 1'b1 && p_at < 0) p_at = i;
            if (bus.long_pulse === 1'b1) begin
                nl++;
                if (l_at < 0) l_at = i;
            end
        end
        n_checks++;
        if (p_at != 0 || l_at != 8 || nl != 1 || nr != 0) begin
            n_fail++;
            $display("FAIL midhold_recount: press_at=%0d long_at=%0d long=%0d rel=%0d want 0 8 1 0",
                     p_at, l_at, nl, nr);
        end
        bus.ButtonIn = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_boundary();
        int nr, nl, nheld;
        nr = 0; nl = 0; nheld = 0;
        bus.ButtonIn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            nl += int'(bus.long_pulse);
            if (bus.state === 2'd2) nheld++;
        end
        bus.ButtonIn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            nr += int'(bus.release_pulse);
            nl += int'(bus.long_pulse);
            if (bus.state === 2'd2) nheld++;
        end
        n_checks++;
        if (nl != 0 || nheld != 0 || nr != 1) begin
            n_fail++;
            $display("FAIL boundary_release: long=%0d held=%0d rel=%0d want 0 0 1", nl, nheld, nr);
        end
        n_checks++;
        if (bus.state !== 2'd0) begin
            n_fail++;
            $display("FAIL boundary_state: state=%0d want 0", bus.state);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_short_press();
        test_long_press();
        test_clear_rules();
        test_reset_mid_hold();
        test_boundary();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
